// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared state type, blanking helpers and standard modes for video_timing_gen
package video_timing_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} vtg_state_t;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    bit hs_pol;
    bit vs_pol;
  } vtg_mode_t;

  localparam vtg_mode_t MODE_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam vtg_mode_t MODE_800X600_60  = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  localparam vtg_mode_t MODE_1280X720_60 = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};

  function automatic int h_tot(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_tot(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - frame-buffer read port and encoder-facing video bus
interface video_timing_gen_if #(
  parameter int NUM_CH = 3,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 21
);
  logic [ADDR_W-1:0]       rd_addr;
  logic                    rd_en;
  logic [NUM_CH*PIX_W-1:0] pix_i;
  logic [NUM_CH*PIX_W-1:0] pix_o;
  logic                    de_o;
  logic                    hsync_o;
  logic                    vsync_o;
  logic                    sof_o;

  modport master (
    output rd_addr, rd_en, pix_o, de_o, hsync_o, vsync_o, sof_o,
    input  pix_i
  );

  modport slave (
    input  rd_addr, rd_en, pix_o, de_o, hsync_o, vsync_o, sof_o,
    output pix_i
  );
endinterface

// File: rtl/vtg_delay_line.sv
// rtl/vtg_delay_line.sv - fixed-depth shift register that lines timing flags up with returned pixel data
module vtg_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_low,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk_low or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised pixel-clock timing generator with frame-buffer prefetch
// VIDEO_TIMING_GEN_PATTERN_EN adds pat_sel, which swaps pix_i for eight vertical colour bars.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int NUM_CH    = 3,
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 21,
  parameter int FETCH_LAT = 2
) (
  input  logic               clk_low,
  input  logic               reset,
  input  logic               en,
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  input  logic               pat_sel,
`endif
  video_timing_gen_if.master vif,
  output logic [15:0]        frame_cnt,
  output logic               busy
);
  localparam int HT = h_tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = v_tot(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [15:0] HT_M1 = 16'(HT - 1);
  localparam logic [15:0] VT_M1 = 16'(VT - 1);
  localparam logic [15:0] HA    = 16'(H_ACTIVE);
  localparam logic [15:0] VA    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_B  = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_E  = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_B  = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_E  = 16'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  localparam int SW = 7;
`else
  localparam int SW = 4;
`endif

  vtg_state_t              state, state_nx;
  logic [15:0]             cx, cx_nx, cy, cy_nx;
  logic                    run, act0, hs0, vs0, sof0, frame_done;
  logic [ADDR_W-1:0]       addr_cnt;
  logic [SW-1:0]           s0, s1, sd;
  logic [NUM_CH*PIX_W-1:0] src_pix;

  assign run        = (state == RUN);
  assign busy       = run;
  assign act0       = run && (cx < HA) && (cy < VA);
  assign hs0        = run && (cx >= HS_B) && (cx < HS_E);
  assign vs0        = run && (cy >= VS_B) && (cy < VS_E);
  assign sof0       = run && (cx == 16'd0) && (cy == 16'd0);
  assign frame_done = run && (cx == HT_M1) && (cy == VT_M1);

  always_comb begin
    state_nx = state;
    cx_nx    = cx;
    cy_nx    = cy;
    case (state)
      IDLE: begin
        cx_nx = '0;
        cy_nx = '0;
        if (en) state_nx = RUN;
      end
      RUN: begin
        if (cx != HT_M1) begin
          cx_nx = cx + 16'd1;
        end else begin
          cx_nx = '0;
          if (cy != VT_M1) begin
            cy_nx = cy + 16'd1;
          end else begin
            // en is only looked at here, so a running frame always completes
            cy_nx = '0;
            if (!en) state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_low or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cx        <= '0;
      cy        <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      cx    <= cx_nx;
      cy    <= cy_nx;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
  logic [2:0]              bar0;
  logic [NUM_CH*PIX_W-1:0] bar_pix;
  assign bar0 = 3'((32'(cx) * 32'd8) / 32'(H_ACTIVE));
  assign s0   = {bar0, sof0, vs0, hs0, act0};

  always_comb begin
    bar_pix = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (c < 3 && sd[4 + c]) bar_pix[c*PIX_W +: PIX_W] = '1;
  end
  assign src_pix = pat_sel ? bar_pix : vif.pix_i;
`else
  assign s0      = {sof0, vs0, hs0, act0};
  assign src_pix = vif.pix_i;
`endif

  // Stage 1 issues the read; every flag rides alongside it from here on.
  always_ff @(posedge clk_low or negedge reset) begin
    if (!reset) begin
      s1          <= '0;
      addr_cnt    <= '0;
      vif.rd_addr <= '0;
    end else begin
      s1 <= s0;
      if (act0) begin
        vif.rd_addr <= addr_cnt;
        addr_cnt    <= addr_cnt + ADDR_W'(1);
      end else if (frame_done) begin
        vif.rd_addr <= '0;
        addr_cnt    <= '0;
      end
    end
  end
  assign vif.rd_en = s1[0];

  vtg_delay_line #(.WIDTH(SW), .DEPTH(FETCH_LAT)) u_align (
    .clk_low (clk_low),
    .reset   (reset),
    .din     (s1),
    .dout    (sd)
  );

  always_ff @(posedge clk_low or negedge reset) begin
    if (!reset) begin
      vif.pix_o   <= '0;
      vif.de_o    <= 1'b0;
      vif.hsync_o <= ~HS_POL;
      vif.vsync_o <= ~VS_POL;
      vif.sof_o   <= 1'b0;
    end else begin
      vif.pix_o   <= sd[0] ? src_pix : '0;
      vif.de_o    <= sd[0];
      vif.hsync_o <= sd[1] ? HS_POL : ~HS_POL;
      vif.vsync_o <= sd[2] ? VS_POL : ~VS_POL;
      vif.sof_o   <= sd[3];
    end
  end
endmodule
